mem_access_unit: RTL and testbench

MEM-stage data-access controller of the 5-stage MIPS pipeline; it produces the data that the MEM/WB latch captures. It takes the EX/MEM latch outputs, runs the dREN/dWEN/dhit handshake with the memory controller, and stalls the pipeline while an access is outstanding. It presents writeback fields (register write enable, destination, write data, halt) that stay stable until the MEM/WB latch captures them on ihit. It also records the latency of the most recent data access.

---
 rtl/mem_access_unit.sv | 88 ++++++++
 tb/tb_mem_access_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-access controller; runs the dREN/dWEN/dhit handshake, stalls the pipeline and feeds the MEM/WB latch
// Ports: CLK, nRST (async active-low); ihit pipeline advance; ex_* EX/MEM latch fields;
//        dhit/dload from memory controller; dREN/dWEN/daddr/dstore request; mem_stall;
//        wb_regWEN/wb_wsel/wb_wdat/wb_halt to MEM/WB; last_latency of the last completed access.
module mem_access_unit #(
  parameter int LAT_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             ex_valid,
  input  logic             ex_dREN,
  input  logic             ex_dWEN,
  input  logic [31:0]      ex_aluresult,
  input  logic [31:0]      ex_store,
  input  logic             ex_regWEN,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_halt,
  input  logic             dhit,
  input  logic [31:0]      dload,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  output logic             mem_stall,
  output logic             wb_regWEN,
  output logic [4:0]       wb_wsel,
  output logic [31:0]      wb_wdat,
  output logic             wb_halt,
  output logic [LAT_W-1:0] last_latency
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, HALTED} state_t;
  state_t           state;
  logic [31:0]      req_addr, req_store, cap_dat;
  logic [4:0]       req_wsel;
  logic             req_regwen, req_st;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic             mem_op;
  assign mem_op = ex_valid & (ex_dREN | ex_dWEN);
  assign cnt_n  = &cnt ? cnt : cnt + LAT_W'(1);
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_store    <= '0;
      cap_dat      <= '0;
      req_wsel     <= '0;
      req_regwen   <= 1'b0;
      req_st       <= 1'b0;
      cnt          <= '0;
      last_latency <= '0;
    end else begin
      case (state)
        IDLE:
          if (mem_op) begin
            req_addr   <= ex_aluresult;
            req_store  <= ex_store;
            req_wsel   <= ex_wsel;
            req_regwen <= ex_regWEN;
            req_st     <= ex_dWEN;
            cnt        <= '0;
            state      <= ACCESS;
          end else if (ex_valid & ex_halt & ihit) state <= HALTED;
        ACCESS: begin
          cnt <= cnt_n;
          if (dhit) begin
            if (!req_st) cap_dat <= dload;
            last_latency <= cnt_n;
            state        <= HOLD;
          end
        end
        HOLD: if (ihit) state <= IDLE;
        default: ;
      endcase
    end
  end
  assign dREN      = (state == ACCESS) & ~req_st;
  assign dWEN      = (state == ACCESS) & req_st;
  assign daddr     = req_addr;
  assign dstore    = req_store;
  assign mem_stall = (state == ACCESS) | ((state == IDLE) & mem_op);
  // a memory op waiting for acceptance must not write back its ALU result
  assign wb_regWEN = (state == IDLE) ? ex_regWEN & ex_valid & ~mem_op :
                     (state == HOLD) ? req_regwen & ~req_st : 1'b0;
  assign wb_wsel   = (state == IDLE) ? ex_wsel : req_wsel;
  assign wb_wdat   = (state == IDLE) ? ex_aluresult : req_st ? req_addr : cap_dat;
  assign wb_halt   = (state == IDLE) ? ex_halt & ex_valid : state == HALTED;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  logic        CLK = 1'b0, nRST;
  logic        ihit, ex_valid, ex_dREN, ex_dWEN, ex_regWEN, ex_halt, dhit;
  logic [31:0] ex_aluresult, ex_store, dload;
  logic [4:0]  ex_wsel;
  logic        dREN, dWEN, mem_stall, wb_regWEN, wb_halt;
  logic [31:0] daddr, dstore, wb_wdat;
  logic [4:0]  wb_wsel;
  logic [7:0]  last_latency;
  logic [37:0] q[$];
  int          checks = 0, fails = 0;

  mem_access_unit #(.LAT_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .ex_valid(ex_valid), .ex_dREN(ex_dREN),
    .ex_dWEN(ex_dWEN), .ex_aluresult(ex_aluresult), .ex_store(ex_store),
    .ex_regWEN(ex_regWEN), .ex_wsel(ex_wsel), .ex_halt(ex_halt), .dhit(dhit),
    .dload(dload), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .mem_stall(mem_stall), .wb_regWEN(wb_regWEN), .wb_wsel(wb_wsel),
    .wb_wdat(wb_wdat), .wb_halt(wb_halt), .last_latency(last_latency)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_regWEN = 0; ex_halt = 0;
    ex_aluresult = '0; ex_store = '0; ex_wsel = '0;
  endtask

  function automatic logic [113:0] all_outs();
    return {dREN, dWEN, daddr, dstore, mem_stall, wb_regWEN, wb_wsel, wb_wdat, wb_halt, last_latency};
  endfunction

  task automatic do_mem(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wsel, input logic rw, input int dly,
                        input logic [31:0] ld, input logic [7:0] lat);
    int ns, nr, nw;
    logic [37:0] e;
    ns = 0; nr = 0; nw = 0;
    ex_valid = 1; ex_dREN = rd; ex_dWEN = wr; ex_aluresult = addr; ex_store = data;
    ex_wsel = wsel; ex_regWEN = rw; ex_halt = 0; ihit = 0;
    #1;
    q.push_back({rw & ~wr, wsel, wr ? addr : ld});
    ns += int'(mem_stall);
    check("accept_req", {dREN, dWEN}, 0);
    for (int c = 1; c <= dly; c++) begin
      @(posedge CLK); #1;
      ns += int'(mem_stall); nr += int'(dREN); nw += int'(dWEN);
      if (c == 1) begin
        check("daddr", daddr, addr);
        check("dstore", dstore, data);
      end
      if (c == dly) begin dhit = 1; dload = ld; end
    end
    @(posedge CLK); #1;
    dhit = 0; dload = 32'hBAD0BAD0;
    check("stall_cycles", ns, dly + 1);
    check("dren_cycles", nr, wr ? 0 : dly);
    check("dwen_cycles", nw, wr ? dly : 0);
    ex_aluresult = 32'hFFFF0000; ex_wsel = 5'd31; ex_regWEN = 1;
    #1;
    check("hold_stall", mem_stall, 0);
    check("hold_req", {dREN, dWEN}, 0);
    check("latency", last_latency, lat);
    e = q.pop_front();
    check("wb", {wb_regWEN, wb_wsel, wb_wdat}, e);
    @(posedge CLK); #1;
    check("hold_keep", {wb_regWEN, wb_wsel, wb_wdat}, e);
    ihit = 1; ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_regWEN = 0;
    @(posedge CLK); #1;
    ihit = 0;
    #1;
    check("back_idle", {mem_stall, wb_wdat}, {1'b0, 32'hFFFF0000});
  endtask

  task automatic do_alu(input logic [31:0] res, input logic [4:0] wsel);
    ex_valid = 1; ex_dREN = 0; ex_dWEN = 0; ex_regWEN = 1; ex_halt = 0;
    ex_aluresult = res; ex_wsel = wsel; ihit = 1;
    #1;
    q.push_back({1'b1, wsel, res});
    check("alu_stall", mem_stall, 0);
    check("alu_req", {dREN, dWEN}, 0);
    check("alu_wb", {wb_regWEN, wb_wsel, wb_wdat}, q.pop_front());
    @(posedge CLK); #1;
    ihit = 0; clear_ex();
  endtask

  initial begin
    int n;
    nRST = 0; ihit = 0; dhit = 0; dload = '0;
    clear_ex();
    #1;
    check("reset", all_outs(), 0);
    #12 nRST = 1;
    @(posedge CLK); #1;
    do_mem(1, 0, 32'h200, 32'h0, 5'd5, 1, 3, 32'hDEADBEEF, 8'd3);
    do_mem(0, 1, 32'h100, 32'h1234, 5'd7, 1, 1, 32'h0, 8'd1);
    do_alu(32'h42, 5'd9);
    do_mem(1, 1, 32'h300, 32'hCAFE, 5'd3, 0, 300, 32'h0, 8'd255);
    do_mem(1, 0, 32'h44, 32'h0, 5'd12, 1, 2, 32'h5555AAAA, 8'd2);
    ex_valid = 1; ex_halt = 1; ihit = 1;
    #1;
    check("halt_pass", wb_halt, 1);
    @(posedge CLK); #1;
    clear_ex(); ihit = 0;
    #1;
    check("halted", {wb_halt, wb_regWEN}, 2'b10);
    ex_valid = 1; ex_dREN = 1; ex_regWEN = 1; ex_aluresult = 32'h80;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      n += int'(dREN) + int'(mem_stall);
    end
    check("halted_noreq", n, 0);
    check("halted_keep", wb_halt, 1);
    clear_ex();
    nRST = 0; #1 nRST = 1;
    @(posedge CLK); #1;
    ex_valid = 1; ex_dREN = 1; ex_aluresult = 32'h500; ex_wsel = 5'd4; ex_regWEN = 1;
    @(posedge CLK); #1;
    clear_ex();
    @(posedge CLK); #1;
    check("pre_rst_dren", dREN, 1);
    #2 nRST = 0;
    #1;
    check("async_rst", all_outs(), 0);
    #3 nRST = 1;
    @(posedge CLK); #1;
    dhit = 1; dload = 32'h77777777;
    @(posedge CLK); #1;
    dhit = 0;
    check("stray_dhit", {dREN, dWEN, mem_stall, last_latency}, 0);
    do_alu(32'h1357, 5'd21);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
